// File: rtl/conv_window_sched.sv
// conv_window_sched: issues every 3x3 window of a tile in raster order under a credit limit
// and writes the in-order results to the output buffer. Define CONV_WINDOW_SCHED_PERF_EN for perf counters.
module conv_window_sched #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int ACC_W   = 16,
  parameter int MAX_OUT = 4,
  localparam int OUT_W  = IMG_W - K + 1,
  localparam int OUT_H  = IMG_H - K + 1,
  localparam int N_OUT  = OUT_W * OUT_H,
  localparam int RW     = $clog2(IMG_H),
  localparam int CW     = $clog2(IMG_W),
  localparam int AW     = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [RW-1:0]           win_row,
  output logic [CW-1:0]           win_col,
  output logic                    win_last,
  input  logic                    res_valid,
  input  logic signed [ACC_W-1:0] res_data,
  output logic                    ob_we,
  output logic [AW-1:0]           ob_addr,
  output logic signed [ACC_W-1:0] ob_data
`ifdef CONV_WINDOW_SCHED_PERF_EN
  ,
  output logic [15:0]             perf_busy_cyc,
  output logic [15:0]             perf_stall_cyc
`endif
);

  localparam int CNT_W = $clog2(N_OUT + 1);
  localparam int OW    = $clog2(MAX_OUT + 1);

  localparam logic [CNT_W-1:0] N_OUT_C   = CNT_W'(N_OUT);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(N_OUT - 1);
  localparam logic [OW-1:0]    MAX_OUT_C = OW'(MAX_OUT);
  localparam logic [CW-1:0]    COL_MAX_C = CW'(OUT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic [CNT_W-1:0]        iss_cnt_q;
  logic [CNT_W-1:0]        res_cnt_q;
  logic [OW-1:0]           out_q;
  logic [OW-1:0]           out_d;
  logic                    err_q;
  logic                    err_d;
  logic                    busy_q;
  logic                    done_q;
  logic                    ob_we_q;
  logic [AW-1:0]           ob_addr_q;
  logic signed [ACC_W-1:0] ob_data_q;

  logic in_issue_s;
  logic win_valid_s;
  logic hs_s;
  logic last_s;
  logic res_acc_s;
  logic spur_s;
  logic start_acc_s;

  // Handshake qualification and outstanding/err next-state; credit check uses only registered count.
  always_comb begin
    in_issue_s  = (state_q == S_ISSUE);
    win_valid_s = in_issue_s && (out_q < MAX_OUT_C);
    hs_s        = win_valid_s && win_ready;
    last_s      = in_issue_s && (iss_cnt_q == LAST_C);
    res_acc_s   = res_valid && (out_q != OW'(0));
    spur_s      = res_valid && (out_q == OW'(0));
    start_acc_s = (state_q == S_IDLE) && start;
    out_d       = out_q;
    if (start_acc_s) begin
      out_d = OW'(0);
    end else begin
      case ({hs_s, res_acc_s})
        2'b10:   out_d = out_q + OW'(1);
        2'b01:   out_d = out_q - OW'(1);
        default: out_d = out_q;
      endcase
    end
    if (start_acc_s) begin
      err_d = spur_s;
    end else begin
      err_d = err_q | spur_s;
    end
  end

  // Sequencer FSM with window coordinates, result writeback and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= RW'(0);
      col_q     <= CW'(0);
      iss_cnt_q <= CNT_W'(0);
      res_cnt_q <= CNT_W'(0);
      out_q     <= OW'(0);
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ob_we_q   <= 1'b0;
      ob_addr_q <= AW'(0);
      ob_data_q <= ACC_W'(0);
    end else begin
      out_q   <= out_d;
      err_q   <= err_d;
      done_q  <= 1'b0;
      ob_we_q <= res_acc_s;
      if (res_acc_s) begin
        ob_addr_q <= res_cnt_q[AW-1:0];
        ob_data_q <= res_data;
        res_cnt_q <= res_cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_ISSUE;
            busy_q    <= 1'b1;
            row_q     <= RW'(0);
            col_q     <= CW'(0);
            iss_cnt_q <= CNT_W'(0);
            res_cnt_q <= CNT_W'(0);
          end
        end
        S_ISSUE: begin
          if (hs_s) begin
            if (iss_cnt_q != N_OUT_C) begin
              iss_cnt_q <= iss_cnt_q + CNT_W'(1);
            end
            // The final window keeps its coordinates; nothing is presented after it.
            if (last_s) begin
              state_q <= S_DRAIN;
            end else if (col_q == COL_MAX_C) begin
              col_q <= CW'(0);
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (res_cnt_q == N_OUT_C) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign win_valid = win_valid_s;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign win_last  = last_s;
  assign ob_we     = ob_we_q;
  assign ob_addr   = ob_addr_q;
  assign ob_data   = ob_data_q;

`ifdef CONV_WINDOW_SCHED_PERF_EN
  logic [15:0] perf_busy_q;
  logic [15:0] perf_stall_q;

  // Saturating busy and stall cycle counters, cleared when a tile begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_q  <= 16'h0000;
      perf_stall_q <= 16'h0000;
    end else if (start_acc_s) begin
      perf_busy_q  <= 16'h0000;
      perf_stall_q <= 16'h0000;
    end else begin
      if (busy_q && (perf_busy_q != 16'hFFFF)) begin
        perf_busy_q <= perf_busy_q + 16'h0001;
      end
      if (win_valid_s && !win_ready && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'h0001;
      end
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Randomized self-checking bench for conv_window_sched against a queue-based datapath/raster model.
module tb_conv_window_sched;

  localparam int OUT_W   = 6;
  localparam int N_OUT   = 36;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, win_valid, win_last, ob_we;
  logic        win_ready = 1'b0;
  logic [2:0]  win_row, win_col;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = 16'h0000;
  logic [5:0]  ob_addr;
  logic [15:0] ob_data;
`ifdef CONV_WINDOW_SCHED_PERF_EN
  logic [15:0] perf_busy_cyc, perf_stall_cyc;
`endif

  conv_window_sched dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .win_last(win_last), .res_valid(res_valid), .res_data(res_data),
    .ob_we(ob_we), .ob_addr(ob_addr), .ob_data(ob_data)
`ifdef CONV_WINDOW_SCHED_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  int issued, returned, outst, exp_wr, done_cnt;
  int pend_due[$];
  logic [15:0] exp_data [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // mode: 0 ready=1 fixed latency 2, 1 ready 1,0,0,1, 2 random ready + stray starts, 3 credit hold
  task automatic run_tile(input int mode, input int lat_max, input int abort_after);
    int  cyc, ready_ph, lat;
    bit  fin, rdy, rv, hs, allow, aborted, stalled_prev;
    logic [2:0] prow, pcol;
    logic [15:0] dat;
    issued = 0; returned = 0; outst = 0; exp_wr = 0; done_cnt = 0;
    pend_due.delete();
    fin = 0; aborted = 0; stalled_prev = 0; ready_ph = 0; prow = 3'd0; pcol = 3'd0;
    @(negedge clk);
    start = 1'b1; win_ready = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);
    cyc = 0;
    while (!fin && cyc < 2000) begin
      chk("win_valid", win_valid, (issued < N_OUT) && (outst < MAX_OUT));
      if (win_valid) begin
        chk("win_row", win_row, issued / OUT_W);
        chk("win_col", win_col, issued % OUT_W);
        chk("win_last", win_last, issued == N_OUT - 1);
      end
      if (stalled_prev) begin
        chk("stall_row_stable", win_row, prow);
        chk("stall_col_stable", win_col, pcol);
      end
      if (ob_we) begin
        chk("ob_addr", ob_addr, exp_wr);
        chk("ob_data", ob_data, exp_data[exp_wr]);
        exp_wr++;
      end
      chk("err_clear", err, 0);
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        fin = 1;
      end else begin
        chk("busy_in_tile", busy, 1);
      end
      if (mode == 3 && cyc == 29) chk("credit_hold", issued, MAX_OUT);
      if (mode == 3 && cyc == 45) chk("credit_one_more", issued, MAX_OUT + 1);
      if (abort_after > 0 && issued == abort_after) begin
        reset = 1'b1; start = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", win_valid, 0);
        chk("rst_ob_we", ob_we, 0);
        reset = 1'b0;
        aborted = 1;
        fin = 1;
      end else if (fin) begin
        start = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
      end else begin
        case (mode)
          1:       rdy = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
          2:       rdy = ($urandom % 2) == 1;
          default: rdy = 1'b1;
        endcase
        ready_ph++;
        if (mode == 3) allow = (cyc == 30) || (cyc >= 46);
        else           allow = 1'b1;
        rv = 0; dat = 16'h0000;
        if (allow && pend_due.size() > 0 && pend_due[0] <= cyc) begin
          rv = 1;
          void'(pend_due.pop_front());
          dat = (mode == 0) ? 16'(100 + returned) : 16'($urandom);
          exp_data[returned] = dat;
          returned++;
        end
        hs = win_valid && rdy;
        if (hs) begin
          lat = (mode == 0 || mode == 3) ? 2 : 1 + int'($urandom % lat_max);
          pend_due.push_back(cyc + lat);
          issued++;
        end
        outst = outst + int'(hs) - int'(rv);
        stalled_prev = win_valid && !rdy;
        prow = win_row; pcol = win_col;
        win_ready = rdy; res_valid = rv; res_data = dat;
        start = (mode == 2) ? (($urandom % 8) == 0) : 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (!aborted) begin
      chk("done_count", done_cnt, 1);
      chk("issued_total", issued, N_OUT);
      chk("writes_total", exp_wr, N_OUT);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_ob_we", ob_we, 0);
        chk("post_valid", win_valid, 0);
        chk("post_err", err, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_ob_we", ob_we, 0);
    chk("rst_ob_addr", ob_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    run_tile(0, 2, 0);
    run_tile(1, 3, 0);
    run_tile(3, 2, 0);

    // spurious result in IDLE
    res_valid = 1'b1; res_data = 16'h1234;
    @(negedge clk);
    res_valid = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_ob_we", ob_we, 0);
    @(negedge clk);
    chk("spur_err_sticky", err, 1);
    chk("spur_ob_we2", ob_we, 0);
    run_tile(2, 4, 0);

    run_tile(2, 4, 10);
    run_tile(0, 2, 0);
    for (int r = 0; r < 3; r++) run_tile(2, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequencer for the 3x3 2D convolution datapath.
- On a start pulse it issues every valid 3x3 window position of an IMG_H x IMG_W tile, in raster order, to the multiply/accumulate datapath over a valid/ready handshake.
- Enforces a credit limit on windows in flight.
- Writes each returning result to the output buffer at its raster address, then pulses done.

Parameters:
- IMG_W, 8, input tile width.
- IMG_H, 8, input tile height.
- K, 3, kernel size. Derived: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1, N_OUT = OUT_W*OUT_H (36).
- ACC_W, 16, signed result width.
- MAX_OUT, 4, maximum windows issued but not yet returned (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a tile; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when all N_OUT results are written.
- err  out  1  sticky; result arrived with nothing outstanding; cleared on accepted start.
- win_valid  out  1  window coordinate valid.
- win_ready  in  1  datapath accepts the window.
- win_row  out  clog2(IMG_H)  top-left row of window.
- win_col  out  clog2(IMG_W)  top-left column of window.
- win_last  out  1  high with the final window (OUT_H-1, OUT_W-1).
- res_valid  in  1  datapath result strobe; results return in issue order.
- res_data  in  ACC_W  signed convolution result.
- ob_we  out  1  output buffer write enable.
- ob_addr  out  clog2(N_OUT)  output buffer address, 0..N_OUT-1.
- ob_data  out  ACC_W  output buffer write data.

Behaviour:
- Reset: clk and reset are as above (synchronous, active-high). All outputs reset to 0; state IDLE; all counters 0. Reset mid-operation abandons the tile immediately; no further ob_we.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> ISSUE next cycle. Clears issue counter, result counter, outstanding count and err. start is ignored in every other state.
- ISSUE:
  - win_valid = (outstanding < MAX_OUT). The check uses the registered count, with no same-cycle bypass from res_valid.
  - win_row, win_col and win_last hold stable while win_valid=1 and win_ready=0.
  - On handshake (win_valid & win_ready): col+1. At col=OUT_W-1, col wraps to 0 and row+1.
  - The handshake with win_last=1 moves to DRAIN. win_valid=0 from then on.
- DRAIN: when the result counter reaches N_OUT (last write issued) -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle -> IDLE.
- outstanding: +1 on handshake, -1 on accepted result. A handshake and a result in the same cycle leave it unchanged. It never exceeds MAX_OUT.
- Results:
  - res_valid with outstanding>0 is accepted.
  - One cycle later: ob_we=1, ob_addr = result counter, ob_data = res_data registered. The result counter then increments.
  - Write latency is exactly 1 cycle; back-to-back results give back-to-back writes.
- Spurious result: res_valid with outstanding=0 (any state, including IDLE) sets err=1. It produces no write and does not change counters.
- Widths: counters are sized for N_OUT. The issue counter saturates at N_OUT; no wrap.

Optional Feature:
- Macro CONV_WINDOW_SCHED_PERF_EN.
- Defined:
  - Adds output perf_busy_cyc (16, counts cycles with busy=1).
  - Adds output perf_stall_cyc (16, counts cycles with win_valid=1 and win_ready=0).
  - Both saturate at 16'hFFFF, clear on accepted start and on reset, and hold after done.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Nominal run: win_ready=1 and a 2-cycle datapath returning res_data = 100+index, pulse start.
  - Required: 36 windows (0,0),(0,1)..(0,5),(1,0)..(5,5), with win_last only at (5,5).
  - Required: ob_addr 0..35 with ob_data 100..135.
  - Required: a single done pulse, then busy=0 and err=0.
- Backpressure: win_ready toggled 1,0,0,1 repeatedly.
  - Required: win_row/win_col constant during every ready=0 cycle.
  - Required: no window skipped or duplicated; still 36 writes.
- Credit limit, MAX_OUT=4 and no results returned:
  - Required: exactly 4 handshakes, then win_valid=0 indefinitely.
  - Then one res_valid -> exactly one further handshake.
- Spurious result: res_valid=1 while IDLE.
  - Required: err=1 next cycle, ob_we stays 0.
  - A following start clears err; the run completes normally.
- Reset mid-run: assert reset after 10 handshakes.
  - Required: next cycle busy=0, win_valid=0, ob_we=0.
  - A new start reissues from (0,0) with ob_addr starting at 0.
- start pulses during ISSUE and DRAIN: ignored; exactly one done per accepted start.
